// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared definitions for the pipeline control chain: stage indices,
// per-stage action encoding and the default performance-counter width.
package pipe_pkg;

  // Stage indices of the classic five-stage CPU pipeline registers
  localparam int unsigned STG_IF_ID  = 0;
  localparam int unsigned STG_ID_EX  = 1;
  localparam int unsigned STG_EX_MEM = 2;
  localparam int unsigned STG_MEM_WB = 3;

  localparam int unsigned CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ADVANCE,
    HOLD,
    BUBBLE,
    KILL
  } stage_action_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline register: a valid bit plus payload, updated according to the
// action the chain controller selects for this stage.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  stage_action_e     action,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Apply the selected action on enabled edges; hold otherwise
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (en) begin
      unique case (action)
        ADVANCE: begin
          valid <= src_valid;
          data  <= src_data;
        end
        HOLD: begin
          valid <= valid;
          data  <= data;
        end
        BUBBLE, KILL: begin
          valid <= 1'b0;
          data  <= '0;
        end
        default: begin
          valid <= 1'b0;
          data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Parametrised pipeline-register chain with stall (bubble insertion) and
// flush (redirect kill). Stage 0 is the youngest register.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined;
// otherwise the counter ports are tied to zero.
module pipe_ctrl_chain
  import pipe_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         enable,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic [NUM_STAGES-1:0]        stall_req,
  input  logic [NUM_STAGES-1:0]        flush_req,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic [NUM_STAGES*DATA_W-1:0] stage_data,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             flush_cnt,
  output logic [CNT_W-1:0]             retire_cnt
);

  logic                  stall_any;
  logic                  flush_any;
  int                    s_idx;
  int                    f_idx;
  stage_action_e         action [NUM_STAGES];
  logic [NUM_STAGES-1:0] src_valid;
  logic [DATA_W-1:0]     src_data [NUM_STAGES];
  logic [DATA_W-1:0]     dat [NUM_STAGES];
  logic                  load;

  assign stall_any = |stall_req;
  assign flush_any = |flush_req;
  assign in_ready  = enable & ~stall_any & ~flush_any;
  assign load      = in_valid & in_ready;

  // Highest requesting stage for stall and flush (-1 when none)
  always_comb begin
    s_idx = -1;
    f_idx = -1;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stall_req[i]) s_idx = i;
      if (flush_req[i]) f_idx = i;
    end
  end

  // Per-stage action: kill beats hold beats bubble beats advance
  always_comb begin
    for (int j = 0; j < NUM_STAGES; j++) begin
      action[j] = ADVANCE;
      if (flush_any && j <= f_idx) begin
        action[j] = KILL;
      end else if (stall_any && j <= s_idx) begin
        action[j] = HOLD;
      end else if ((stall_any && j == s_idx + 1) || (flush_any && j == f_idx + 1)) begin
        // Stage below a held region, or whose source was just killed
        action[j] = BUBBLE;
      end
    end
  end

  // Source of each stage: the input for stage 0, the previous stage otherwise
  always_comb begin
    src_valid[0] = load;
    src_data[0]  = load ? in_data : '0;
    for (int j = 1; j < NUM_STAGES; j++) begin
      src_valid[j] = stage_valid[j-1];
      src_data[j]  = dat[j-1];
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    pipe_stage_reg #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk       (clk),
      .arst_n    (arst_n),
      .en        (enable),
      .action    (action[g]),
      .src_valid (src_valid[g]),
      .src_data  (src_data[g]),
      .valid     (stage_valid[g]),
      .data      (dat[g])
    );
    assign stage_data[g*DATA_W +: DATA_W] = dat[g];
  end

  assign out_valid = stage_valid[NUM_STAGES-1];
  assign out_data  = dat[NUM_STAGES-1];

`ifdef PIPE_PERF_CNT_EN
  // Last stage is held exactly when the top stall bit is set
  logic retire;
  assign retire = out_valid & ~stall_req[NUM_STAGES-1];

  // Free-running event counters, wrapping naturally
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else if (enable) begin
      if (stall_any) stall_cnt  <= stall_cnt + 1'b1;
      if (flush_any) flush_cnt  <= flush_cnt + 1'b1;
      if (retire)    retire_cnt <= retire_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed self-checking bench for pipe_ctrl_chain (NUM_STAGES=4, DATA_W=64).
module tb_pipe_ctrl_chain;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 32;

  logic            clk = 1'b0;
  logic            arst_n;
  logic            enable;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic [N-1:0]    stall_req;
  logic [N-1:0]    flush_req;
  logic [N-1:0]    stage_valid;
  logic [N*DW-1:0] stage_data;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   stall_cnt;
  logic [CW-1:0]   flush_cnt;
  logic [CW-1:0]   retire_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  pipe_ctrl_chain #(
    .NUM_STAGES (N),
    .DATA_W     (DW),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] sd(input int i);
    return stage_data[i*DW +: DW];
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d,
                       input logic [N-1:0] st, input logic [N-1:0] fl);
    in_valid  = v;
    in_data   = d;
    stall_req = st;
    flush_req = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < N + 1; i++) tick();
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    enable = 1'b1;
    drive(1'b0, '0, '0, '0);
    #2;
    tests_run++;
    if (stage_valid !== 4'b0000 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b/%b want 0000/0", stage_valid, out_valid);
    end
    tests_run++;
    if (stage_data !== '0 || stall_cnt !== '0 || flush_cnt !== '0 || retire_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h cnt %0d %0d %0d want all 0", stage_data,
               stall_cnt, flush_cnt, retire_cnt);
    end
    tick();
    tick();
    arst_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_free_run();
    drive(1'b1, 64'hA1, '0, '0);
    tick();
    tests_run++;
    if (stage_valid !== 4'b0001 || sd(0) !== 64'hA1) begin
      tests_failed++;
      $display("FAIL free_first: got %b %h want 0001 a1", stage_valid, sd(0));
    end
    drive(1'b1, 64'hA2, '0, '0);
    tick();
    drive(1'b1, 64'hA3, '0, '0);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 64'hA1) begin
      tests_failed++;
      $display("FAIL free_out_a1: got %b %h want 1 a1", out_valid, out_data);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 64'hA2) begin
      tests_failed++;
      $display("FAIL free_out_a2: got %b %h want 1 a2", out_valid, out_data);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 64'hA3) begin
      tests_failed++;
      $display("FAIL free_out_a3: got %b %h want 1 a3", out_valid, out_data);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 64'h0) begin
      tests_failed++;
      $display("FAIL free_out_end: got %b %h want 0 0", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 64'hAF, '0, '0);
    tick();
    drive(1'b1, 64'hB0, '0, '0);
    tick();
    // offered entry must be refused while stalled
    drive(1'b1, 64'hEE, 4'b0001, '0);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_ready: got %b want 0", in_ready);
    end
    tick();
    tests_run++;
    if (stage_valid !== 4'b0101 || sd(0) !== 64'hB0 || sd(1) !== 64'h0 || sd(2) !== 64'hAF) begin
      tests_failed++;
      $display("FAIL load_use_stages: got %b %h %h %h want 0101 b0 0 af", stage_valid,
               sd(0), sd(1), sd(2));
    end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 64'hC3, '0, '0);
    tick();
    drive(1'b1, 64'hC2, '0, '0);
    tick();
    drive(1'b1, 64'hC1, '0, '0);
    tick();
    drive(1'b1, 64'hC0, '0, '0);
    tick();
    drive(1'b0, '0, '0, 4'b0010);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 64'hC3 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_pre: got %b %h rdy %b want 1 c3 rdy 0", out_valid, out_data,
               in_ready);
    end
    tick();
    tests_run++;
    if (stage_valid !== 4'b1000 || sd(3) !== 64'hC2 || sd(2) !== 64'h0 ||
        sd(1) !== 64'h0 || sd(0) !== 64'h0) begin
      tests_failed++;
      $display("FAIL flush_post: got %b %h want 1000 c2/0/0/0", stage_valid, stage_data);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    // stage 1 is already a bubble, so holding it and bubbling it look the same
    drive(1'b1, 64'hD3, '0, '0);
    tick();
    drive(1'b1, 64'hD2, '0, '0);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    drive(1'b1, 64'hD0, '0, '0);
    tick();
    tests_run++;
    if (stage_valid !== 4'b1101) begin
      tests_failed++;
      $display("FAIL simul_pre: got %b want 1101", stage_valid);
    end
    drive(1'b1, 64'h55, 4'b0100, 4'b0001);
    tick();
    tests_run++;
    if (stage_valid !== 4'b0100 || sd(2) !== 64'hD2 || sd(3) !== 64'h0 ||
        sd(1) !== 64'h0 || sd(0) !== 64'h0) begin
      tests_failed++;
      $display("FAIL simul_post: got %b %h want 0100 0/d2/0/0", stage_valid, stage_data);
    end
    drain();
  endtask

  task automatic test_last_stall();
    drive(1'b1, 64'hF3, '0, '0);
    tick();
    drive(1'b1, 64'hF2, '0, '0);
    tick();
    drive(1'b1, 64'hF1, '0, '0);
    tick();
    drive(1'b1, 64'hF0, '0, '0);
    tick();
    drive(1'b1, 64'h77, 4'b1000, '0);
    tick();
    tick();
    tests_run++;
    if (stage_valid !== 4'b1111 || out_data !== 64'hF3 || sd(0) !== 64'hF0 || sd(1) !== 64'hF1) begin
      tests_failed++;
      $display("FAIL last_stall: got %b %h want 1111 f0/f1/f2/f3", stage_valid, stage_data);
    end
  endtask

  task automatic test_freeze_and_reset();
    logic [N*DW-1:0] exp_data;
    exp_data = {64'hF3, 64'hF2, 64'hF1, 64'hF0};
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 64'h99 + c, 4'(c), 4'(c * 3));
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL freeze_ready: cycle %0d got %b want 0", c, in_ready);
      end
      tick();
      tests_run++;
      if (stage_valid !== 4'b1111 || stage_data !== exp_data || out_data !== 64'hF3) begin
        tests_failed++;
        $display("FAIL freeze_hold: cycle %0d got %b %h want 1111 %h", c, stage_valid,
                 stage_data, exp_data);
      end
    end
    enable = 1'b1;
    drive(1'b0, '0, '0, '0);
    #3;
    arst_n = 1'b0;
    #1;
    tests_run++;
    if (stage_valid !== 4'b0000 || stage_data !== '0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got %b %h want 0000 0", stage_valid, stage_data);
    end
    tick();
    arst_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || stage_valid !== 4'b0000) begin
      tests_failed++;
      $display("FAIL post_reset: got rdy %b valid %b want 1 0000", in_ready, stage_valid);
    end
  endtask

  task automatic test_perf_counters();
    logic [CW-1:0] exp_stall;
    logic [CW-1:0] exp_flush;
    logic [CW-1:0] exp_retire;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'h100 + i, '0, '0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 4'b0001, '0);
      tick();
    end
    // kills the fifth entry still held in stage 0
    drive(1'b0, '0, '0, 4'b0001);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'h200 + i, '0, '0);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 8; i++) tick();
`ifdef PIPE_PERF_CNT_EN
    exp_stall  = 3;
    exp_flush  = 1;
    exp_retire = 9;
`else
    exp_stall  = 0;
    exp_flush  = 0;
    exp_retire = 0;
`endif
    tests_run++;
    if (stall_cnt !== exp_stall) begin
      tests_failed++;
      $display("FAIL perf_stall: got %0d want %0d", stall_cnt, exp_stall);
    end
    tests_run++;
    if (flush_cnt !== exp_flush) begin
      tests_failed++;
      $display("FAIL perf_flush: got %0d want %0d", flush_cnt, exp_flush);
    end
    tests_run++;
    if (retire_cnt !== exp_retire) begin
      tests_failed++;
      $display("FAIL perf_retire: got %0d want %0d", retire_cnt, exp_retire);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_use();
    test_flush();
    test_simultaneous();
    test_last_stall();
    test_freeze_and_reset();
    test_perf_counters();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
